// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, holds it for a fixed
// number of wait states, then presents read data (or store echo) until taken.
module data_mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int IDX_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  mem [0:DEPTH-1];

  logic               acc_we;
  logic [ADDR_W-1:0]  acc_addr;
  logic [DATA_W-1:0]  acc_wdata;
  logic [IDX_W-1:0]   acc_idx;
  logic               acc_hit;
  logic [DATA_W-1:0]  acc_rdata;
  logic               enter_resp;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  // With zero wait states the access happens on the accept edge itself, so the
  // live request fields are used from IDLE and the captured copy otherwise.
  assign acc_we    = (state == ST_IDLE) ? req_we    : we_q;
  assign acc_addr  = (state == ST_IDLE) ? req_addr  : addr_q;
  assign acc_wdata = (state == ST_IDLE) ? req_wdata : wdata_q;
  assign acc_idx   = acc_addr[IDX_W-1:0];
  assign acc_hit   = ({1'b0, acc_addr} < DEPTH_L);
  assign acc_rdata = !acc_hit ? '0 : (acc_we ? acc_wdata : mem[acc_idx]);

  assign enter_resp = ((state == ST_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                      ((state == ST_WAIT) && (cnt == '0));

  always_ff @(posedge clk) begin
    if (state == ST_IDLE && req_valid) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Gated by rst so a store abandoned by reset never lands in the array.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && acc_hit && acc_we)
      mem[acc_idx] <= acc_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            if (WAIT_CYCLES == 0) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_rdata <= acc_rdata;
              resp_err   <= !acc_hit;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == '0) begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= acc_rdata;
            resp_err   <= !acc_hit;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state      <= ST_IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a wait-state instance (DEPTH=200)
// driven with random traffic, plus a zero-wait instance for back-to-back flow.
module tb_data_mem_responder;

  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int DEPTH = 200;
  localparam int WC    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid, resp_ready = 1'b0, resp_err, busy;
  logic [DW-1:0] resp_rdata;

  logic          z_req_valid = 1'b0, z_req_ready, z_req_we = 1'b0;
  logic [AW-1:0] z_req_addr = '0;
  logic [DW-1:0] z_req_wdata = '0;
  logic          z_resp_valid, z_resp_ready = 1'b0, z_resp_err, z_busy;
  logic [DW-1:0] z_resp_rdata;

  data_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  data_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .WAIT_CYCLES(0)) u_zero (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .busy(z_busy)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            acc;
  } exp_t;

  exp_t          exp_q[$];
  bit            seen = 1'b0;
  logic [DW-1:0] mem_m [0:DEPTH-1];
  int            cyc = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            rr_mode = 1;  // 0: hold off, 1: random, 2: always ready

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      resp_ready = (rr_mode == 2) ? 1'b1 : (rr_mode == 0) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Reference: one outstanding access; expected result decided from the rules
  // at accept time against a plain array image of the memory.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input bit push);
    exp_t e;
    int   k;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      fail_now("accept_timeout");
      req_valid = 1'b0;
      return;
    end
    e.acc = cyc + 1;
    if (int'(addr) >= DEPTH) begin
      e.rdata = '0;
      e.err   = 1'b1;
    end else if (we) begin
      e.rdata = wd;
      e.err   = 1'b0;
      if (push) mem_m[addr] = wd;
    end else begin
      e.rdata = mem_m[addr];
      e.err   = 1'b0;
    end
    @(posedge clk);
    if (push) exp_q.push_back(e);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_wdata = DW'($urandom);
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
      seen = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_resp_rdata"}, resp_rdata, 0);
    check({tag, "_resp_err"}, resp_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  always @(negedge clk) begin
    if (rst && resp_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_resp: got rdata 0x%0h err %0d, expected no response", resp_rdata, resp_err);
      end else begin
        if (!seen) begin
          check("latency", cyc + 1 - exp_q[0].acc, WC + 1);
          seen = 1'b1;
        end
        check("resp_rdata", resp_rdata, exp_q[0].rdata);
        check("resp_err", resp_err, exp_q[0].err);
        check("ready_busy_in_resp", {req_ready, busy}, 2'b01);
        if (resp_ready) begin
          void'(exp_q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  logic [DW-1:0] m0 [0:7];
  bit            k0 [0:7];

  initial begin
    logic [2:0]    a;
    logic          w;
    logic [DW-1:0] d;
    logic [DW-1:0] pend;
    logic          prev_v;

    // Reset values
    #1;
    check_reset_outputs("rst");
    check("z_rst_ready", z_req_ready, 1);
    check("z_rst_valid", z_resp_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Store/load round trip at addr 5
    issue(1'b1, 8'd5, 16'h1234, 1'b1);
    issue(1'b0, 8'd5, 16'h0, 1'b1);
    drain();

    // Populate the whole implemented range so every later load is predictable
    for (int i = 0; i < DEPTH; i++) issue(1'b1, AW'(i), DW'($urandom), 1'b1);
    drain();

    // Backpressure: response held, a waiting request must not get in
    rr_mode = 0;
    issue(1'b1, 8'd20, 16'h5A5A, 1'b1);
    fork
      issue(1'b0, 8'd20, 16'h0, 1'b1);
      begin
        repeat (WC + 6) @(posedge clk);
        #1 rr_mode = 1;
      end
    join
    drain();

    // Out-of-range store leaves memory alone; aliasing address is unchanged
    issue(1'b1, 8'd250, 16'hAAAA, 1'b1);
    issue(1'b0, 8'd50, 16'h0, 1'b1);
    issue(1'b0, 8'd250, 16'h0, 1'b1);
    drain();

    // Random mixed traffic across the full address space
    for (int i = 0; i < 150; i++)
      issue(1'($urandom), AW'($urandom), DW'($urandom), 1'b1);
    drain();

    // Request waiting while a response is taken: accepted one edge later
    rr_mode = 2;
    for (int i = 0; i < 6; i++)
      issue(1'($urandom), AW'($urandom_range(0, 255)), DW'($urandom), 1'b1);
    drain();
    rr_mode = 1;

    // Reset during WAIT abandons the store
    issue(1'b1, 8'd7, 16'h0000, 1'b1);
    drain();
    issue(1'b1, 8'd7, 16'hBEEF, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    issue(1'b0, 8'd7, 16'h0, 1'b1);
    drain();

    // Zero wait states, both handshakes held high
    z_req_valid  = 1'b1;
    z_resp_ready = 1'b1;
    pend   = '0;
    prev_v = 1'b0;
    for (int i = 0; i < 8; i++) k0[i] = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      a = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      if (!k0[a]) w = 1'b1;
      d = DW'($urandom);
      z_req_we    = w;
      z_req_addr  = {5'd0, a};
      z_req_wdata = d;
      @(negedge clk);
      if (i > 0) check("z_alternate", z_resp_valid, !prev_v);
      prev_v = z_resp_valid;
      check("z_ready_vs_valid", z_req_ready, !z_resp_valid);
      if (z_resp_valid) begin
        check("z_rdata", z_resp_rdata, pend);
        check("z_err", z_resp_err, 0);
      end
      if (z_req_ready) begin
        pend = w ? d : m0[a];
        if (w) begin
          m0[a] = d;
          k0[a] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1 z_req_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
